// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the CPU memory arbiter.
// Two-port bus sharing between instruction fetch and data access.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D
  } arb_state_t;

  localparam int ARB_FIXED_DATA  = 0;
  localparam int ARB_ROUND_ROBIN = 1;

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Requester and bus signal bundle for the memory arbiter.
// slave = arbiter view, master = requester/bus-model view.
interface mips_cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byteenable;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] bus_address;
  logic              bus_read;
  logic              bus_write;
  logic [DATA_W-1:0] bus_writedata;
  logic [BE_W-1:0]   bus_byteenable;
  logic              bus_waitrequest;
  logic [DATA_W-1:0] bus_readdata;

  logic              grant_d;

  modport slave (
    input  if_req, if_addr,
    input  d_read, d_write, d_addr,
    input  d_wdata, d_byteenable,
    input  bus_waitrequest, bus_readdata,
    output if_ready, if_rdata,
    output d_ready, d_rdata,
    output bus_address, bus_read, bus_write,
    output bus_writedata, bus_byteenable,
    output grant_d
  );

  modport master (
    output if_req, if_addr,
    output d_read, d_write, d_addr,
    output d_wdata, d_byteenable,
    output bus_waitrequest, bus_readdata,
    input  if_ready, if_rdata,
    input  d_ready, d_rdata,
    input  bus_address, bus_read, bus_write,
    input  bus_writedata, bus_byteenable,
    input  grant_d
  );

endinterface

// File: rtl/mips_cpu_rr_pick.sv
// Two-way request picker: fixed data priority or alternate on tie.
// Purely combinational so other bus masters can share it.
module mips_cpu_rr_pick (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  input  logic mode,
  output logic grant_i,
  output logic grant_d
);

  // On a tie in round-robin mode, data loses only if it went last.
  assign grant_d = req_d & (~req_i | ~mode | ~last_d);
  assign grant_i = req_i & ~grant_d;

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Serialises fetch and load/store onto one Avalon-style bus.
// Registered bus outputs, registered read data, one-cycle ready pulses.
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int ARB_MODE = ARB_FIXED_DATA,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input logic                  clk,
  input logic                  reset,
  mips_cpu_mem_arbiter_if.slave arb
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q;
  logic              last_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_d_q;

  logic req_i;
  logic req_d;
  logic gnt_i;
  logic gnt_d;

  // A port whose ready is pulsing still shows its old request.
  assign req_i = arb.if_req & ~if_ready_q;
  assign req_d = (arb.d_read | arb.d_write) & ~d_ready_q;

  mips_cpu_rr_pick u_pick (
    .req_i   (req_i),
    .req_d   (req_d),
    .last_d  (last_d_q),
    .mode    (ARB_MODE == ARB_ROUND_ROBIN),
    .grant_i (gnt_i),
    .grant_d (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b1;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      grant_d_q  <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_i) begin
            state_q   <= BUS_I;
            last_d_q  <= 1'b0;
            grant_d_q <= 1'b0;
            addr_q    <= arb.if_addr;
            rd_q      <= 1'b1;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '1;
          end else if (gnt_d) begin
            state_q   <= BUS_D;
            last_d_q  <= 1'b1;
            grant_d_q <= 1'b1;
            addr_q    <= arb.d_addr;
            rd_q      <= arb.d_read & ~arb.d_write;
            wr_q      <= arb.d_write;
            wdata_q   <= arb.d_wdata;
            be_q      <= arb.d_byteenable;
          end
        end
        BUS_I, BUS_D: begin
          if (!arb.bus_waitrequest) begin
            if (state_q == BUS_I) begin
              if_rdata_q <= arb.bus_readdata;
              if_ready_q <= 1'b1;
            end else begin
              if (rd_q) d_rdata_q <= arb.bus_readdata;
              d_ready_q <= 1'b1;
            end
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(arb.d_read && arb.d_write))
        else $error("d_read and d_write both high");
    end
  end

  assign arb.bus_address    = addr_q;
  assign arb.bus_read       = rd_q;
  assign arb.bus_write      = wr_q;
  assign arb.bus_writedata  = wdata_q;
  assign arb.bus_byteenable = be_q;
  assign arb.if_ready       = if_ready_q;
  assign arb.if_rdata       = if_rdata_q;
  assign arb.d_ready        = d_ready_q;
  assign arb.d_rdata        = d_rdata_q;
  assign arb.grant_d        = grant_d_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for the fetch/data memory arbiter.
// Instance a: fixed data priority; instance b: round-robin.
module tb_mips_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rd_a   = 0;
  int   r0;

  always #5 clk = ~clk;

  mips_cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  mips_cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  mips_cpu_mem_arbiter #(
    .ARB_MODE(0), .ADDR_W(32), .DATA_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .arb(a)
  );

  mips_cpu_mem_arbiter #(
    .ARB_MODE(1), .ADDR_W(32), .DATA_W(32)
  ) dut_b (
    .clk(clk), .reset(reset), .arb(b)
  );

  always @(posedge clk)
    if (a.bus_read && !a.bus_waitrequest) rd_a++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  logic [3:0] exp_a;
  logic [3:0] exp_b;

  initial begin
    reset = 1'b1;
    a.if_req = 1'b1; a.if_addr = 32'hBFC00000;
    a.d_read = 1'b0; a.d_write = 1'b0;
    a.d_addr = '0; a.d_wdata = '0; a.d_byteenable = '0;
    a.bus_waitrequest = 1'b0;
    a.bus_readdata = 32'h2402000A;
    b.if_req = 1'b0; b.if_addr = '0;
    b.d_read = 1'b0; b.d_write = 1'b0;
    b.d_addr = '0; b.d_wdata = '0; b.d_byteenable = '0;
    b.bus_waitrequest = 1'b0; b.bus_readdata = '0;

    // reset held two cycles with if_req high
    step(); step();
    chk("rst_bus_read", a.bus_read, 0);
    chk("rst_bus_write", a.bus_write, 0);
    chk("rst_bus_addr", a.bus_address, 0);
    chk("rst_if_ready", a.if_ready, 0);
    chk("rst_d_ready", a.d_ready, 0);
    chk("rst_grant_d", a.grant_d, 0);
    chk("rst_if_rdata", a.if_rdata, 0);
    chk("rst_b_read", b.bus_read, 0);
    reset = 1'b0;
    r0 = rd_a;

    // zero-wait fetch
    step();
    chk("f_strobe", a.bus_read, 1);
    chk("f_addr", a.bus_address, 32'hBFC00000);
    chk("f_be", a.bus_byteenable, 4'hF);
    chk("f_nowrite", a.bus_write, 0);
    chk("f_grant_d", a.grant_d, 0);
    chk("f_early_rdy", a.if_ready, 0);
    step();
    chk("f_ready", a.if_ready, 1);
    chk("f_rdata", a.if_rdata, 32'h2402000A);
    chk("f_strobe_off", a.bus_read, 0);
    a.if_req = 1'b0;
    step();
    chk("f_ready_pulse", a.if_ready, 0);
    chk("f_no_reread", a.bus_read, 0);
    chk("f_rdata_hold", a.if_rdata, 32'h2402000A);
    chk("f_one_read", rd_a - r0, 1);

    // store with three wait cycles
    a.d_write = 1'b1; a.d_addr = 32'h00001000;
    a.d_wdata = 32'hDEADBEEF; a.d_byteenable = 4'b0011;
    a.bus_waitrequest = 1'b1;
    step();
    chk("w_strobe", a.bus_write, 1);
    chk("w_noread", a.bus_read, 0);
    chk("w_addr", a.bus_address, 32'h00001000);
    chk("w_data", a.bus_writedata, 32'hDEADBEEF);
    chk("w_be", a.bus_byteenable, 4'b0011);
    chk("w_grant_d", a.grant_d, 1);
    a.d_addr = 32'h00002000; a.d_wdata = '0;
    a.d_byteenable = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w_hold_wr", a.bus_write, 1);
      chk("w_hold_addr", a.bus_address, 32'h00001000);
      chk("w_hold_data", a.bus_writedata, 32'hDEADBEEF);
      chk("w_hold_be", a.bus_byteenable, 4'b0011);
      chk("w_no_rdy", a.d_ready, 0);
    end
    a.bus_waitrequest = 1'b0;
    step();
    chk("w_ready", a.d_ready, 1);
    chk("w_strobe_off", a.bus_write, 0);
    chk("w_rdata_keep", a.d_rdata, 0);
    chk("w_no_if_rdy", a.if_ready, 0);
    a.d_write = 1'b0;
    step();
    chk("w_ready_pulse", a.d_ready, 0);

    // fetch request held through ready and one cycle more
    a.if_req = 1'b1; a.if_addr = 32'h00000100;
    a.bus_readdata = 32'h11111111;
    r0 = rd_a;
    step();
    chk("h_strobe", a.bus_read, 1);
    chk("h_addr", a.bus_address, 32'h100);
    step();
    chk("h_ready", a.if_ready, 1);
    chk("h_rdata", a.if_rdata, 32'h11111111);
    step();
    chk("h_masked", a.bus_read, 0);
    step();
    chk("h_second", a.bus_read, 1);
    a.if_req = 1'b0;
    step();
    chk("h_ready2", a.if_ready, 1);
    step();
    chk("h_idle", a.bus_read, 0);
    chk("h_two_reads", rd_a - r0, 2);

    // both ports requesting every cycle
    a.if_req = 1'b1; a.if_addr = 32'h300;
    a.d_read = 1'b1; a.d_addr = 32'h400;
    a.bus_readdata = 32'h33333333;
    b.if_req = 1'b1; b.if_addr = 32'h300;
    b.d_read = 1'b1; b.d_addr = 32'h400;
    b.d_byteenable = 4'hF;
    exp_a = 4'b0101;
    exp_b = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("t_a_read", a.bus_read, 1);
      chk("t_a_grant", a.grant_d, exp_a[t]);
      chk("t_a_addr", a.bus_address,
          exp_a[t] ? 32'h400 : 32'h300);
      chk("t_b_read", b.bus_read, 1);
      chk("t_b_grant", b.grant_d, exp_b[t]);
      chk("t_b_addr", b.bus_address,
          exp_b[t] ? 32'h400 : 32'h300);
      step();
      chk("t_a_d_rdy", a.d_ready, exp_a[t]);
      chk("t_a_i_rdy", a.if_ready, !exp_a[t]);
      chk("t_b_d_rdy", b.d_ready, exp_b[t]);
      chk("t_b_i_rdy", b.if_ready, !exp_b[t]);
    end
    a.if_req = 1'b0; a.d_read = 1'b0;
    b.if_req = 1'b0; b.d_read = 1'b0;
    step();
    chk("t_a_quiet", a.bus_read, 0);
    chk("t_b_quiet", b.bus_read, 0);
    chk("t_a_d_rdata", a.d_rdata, 32'h33333333);
    chk("t_a_grant_last", a.grant_d, 0);

    // reset during the second wait cycle of a load
    a.d_read = 1'b1; a.d_addr = 32'h40;
    a.bus_waitrequest = 1'b1;
    step();
    chk("r_strobe", a.bus_read, 1);
    chk("r_grant_d", a.grant_d, 1);
    step();
    chk("r_strobe2", a.bus_read, 1);
    reset = 1'b1;
    step();
    chk("r_abort", a.bus_read, 0);
    chk("r_no_rdy", a.d_ready, 0);
    reset = 1'b0; a.d_read = 1'b0;
    a.bus_waitrequest = 1'b0;
    step();
    chk("r_no_rdy2", a.d_ready, 0);
    chk("r_idle", a.bus_read, 0);
    a.if_req = 1'b1; a.if_addr = 32'h200;
    a.bus_readdata = 32'h22222222;
    step();
    chk("r_f_strobe", a.bus_read, 1);
    chk("r_f_addr", a.bus_address, 32'h200);
    step();
    chk("r_f_ready", a.if_ready, 1);
    chk("r_f_rdata", a.if_rdata, 32'h22222222);
    chk("r_f_no_d", a.d_ready, 0);
    a.if_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
